// File: rtl/scc_mem_dump.sv
// Post-HALT data-memory dump sequencer: walks word addresses, assembles big-endian
// words from byte reads and emits {address, value} records on a valid/ready stream.
module scc_mem_dump #(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = {{(ADDR_W-2){1'b1}}, 2'b00},
  parameter bit                SKIP_ZERO  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_f,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_addr,
  output logic [31:0]       out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CHECK = 3'd2,
    EMIT  = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [2:0]        k_q, k_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       out_addr_q, out_addr_d;
  logic [31:0]       out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              halt_q;
  logic              halt_seen_q;
  logic              start;

  // halt_seen_q keeps a level that is already high at reset release from
  // looking like a 0->1 edge: an edge needs a real sampled 0 first.
  assign start = halt_seen_q && !halt_q && halt_f && (state_q == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= START_ADDR;
      k_q         <= 3'd0;
      word_q      <= 32'd0;
      out_addr_q  <= 32'd0;
      out_data_q  <= 32'd0;
      out_last_q  <= 1'b0;
      halt_q      <= 1'b0;
      halt_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      k_q         <= k_d;
      word_q      <= word_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      halt_q      <= halt_f;
      halt_seen_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    k_d        = k_q;
    word_d     = word_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          ptr_d   = START_ADDR;
          k_d     = 3'd0;
        end
      end
      FETCH: begin
        // Read data lags the strobe by one cycle, so k captures lane k-1.
        case (k_q)
          3'd1:    word_d[31:24] = mem_rd_data;
          3'd2:    word_d[23:16] = mem_rd_data;
          3'd3:    word_d[15:8]  = mem_rd_data;
          3'd4:    word_d[7:0]   = mem_rd_data;
          default: ;
        endcase
        if (k_q == 3'd4) begin
          state_d = CHECK;
          k_d     = 3'd0;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      CHECK: begin
        if (SKIP_ZERO && (word_q == 32'd0)) begin
          state_d = NEXT;
        end else begin
          out_addr_d = 32'(ptr_q);
          out_data_d = word_q;
          out_last_d = (ptr_q == END_ADDR);
          state_d    = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) state_d = NEXT;
      end
      NEXT: begin
        // Compare before incrementing so the top word address never wraps.
        if (ptr_q == END_ADDR) begin
          state_d = DONE;
        end else begin
          ptr_d   = ptr_q + ADDR_W'(4);
          k_d     = 3'd0;
          state_d = FETCH;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_rd_en   = (state_q == FETCH) && (k_q != 3'd4);
  assign mem_rd_addr = mem_rd_en ? (ptr_q + ADDR_W'(k_q)) : '0;
  assign out_valid   = (state_q == EMIT);
  assign out_addr    = out_addr_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign busy        = (state_q == FETCH) || (state_q == CHECK) ||
                       (state_q == EMIT)  || (state_q == NEXT);
  assign done        = (state_q == DONE);

endmodule
